// File: rtl/rob_client_arbiter_if.sv
// Client-side and ROB-side request/response signals of the ROB client arbiter.
// master is the arbiter's view; slave is the surrounding environment's view.
interface rob_client_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int AWIDTH  = 40,
  parameter int DWIDTH  = 32,
  parameter int PWIDTH  = 32,
  parameter int IDWIDTH = 16
);
  logic [NREQ-1:0]        cl_req_val;
  logic [NREQ*AWIDTH-1:0] cl_req_addr;
  logic [NREQ*PWIDTH-1:0] cl_req_param;
  logic [NREQ-1:0]        cl_req_ready;
  logic [NREQ-1:0]        cl_rsp_val;
  logic [DWIDTH-1:0]      cl_rsp_data;
  logic [PWIDTH-1:0]      cl_rsp_param;
  logic [NREQ-1:0]        cl_rsp_ready;
  logic                   rob_req_val;
  logic [AWIDTH-1:0]      rob_req_addr;
  logic [IDWIDTH-1:0]     rob_req_ID;
  logic [PWIDTH-1:0]      rob_req_param;
  logic                   rob_req_ready;
  logic                   rob_rsp_val;
  logic [DWIDTH-1:0]      rob_rsp_data;
  logic [IDWIDTH-1:0]     rob_rsp_ID;
  logic [PWIDTH-1:0]      rob_rsp_param;
  logic                   rob_rsp_ready;
  logic                   err_id;
  logic                   err_orphan;

  modport master (
    input  cl_req_val, cl_req_addr, cl_req_param, cl_rsp_ready,
           rob_req_ready, rob_rsp_val, rob_rsp_data, rob_rsp_ID, rob_rsp_param,
    output cl_req_ready, cl_rsp_val, cl_rsp_data, cl_rsp_param,
           rob_req_val, rob_req_addr, rob_req_ID, rob_req_param, rob_rsp_ready,
           err_id, err_orphan
  );

  modport slave (
    output cl_req_val, cl_req_addr, cl_req_param, cl_rsp_ready,
           rob_req_ready, rob_rsp_val, rob_rsp_data, rob_rsp_ID, rob_rsp_param,
    input  cl_req_ready, cl_rsp_val, cl_rsp_data, cl_rsp_param,
           rob_req_val, rob_req_addr, rob_req_ID, rob_req_param, rob_rsp_ready,
           err_id, err_orphan
  );
endinterface

// File: rtl/rob_client_arbiter.sv
// Round-robin share of one ROB request port among NREQ credit-limited clients; zero-cycle accept,
// responses routed back in ID order through a source FIFO of {client, ID}.
module rob_client_arbiter #(
  parameter int NREQ     = 4,
  parameter int NWIDTH   = 2,
  parameter int SQ_DEPTH = 16,
  parameter int SQ_PTR   = 4,
  parameter int MAX_OUT  = 8,
  parameter int AWIDTH   = 40,
  parameter int DWIDTH   = 32,
  parameter int PWIDTH   = 32,
  parameter int IDWIDTH  = 16
) (
  input logic                clk,
  input logic                rst,
  rob_client_arbiter_if.master bus
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]   CNT_MAX     = CW'(MAX_OUT);
  localparam logic [SQ_PTR:0] SQ_FULL_CNT = (SQ_PTR + 1)'(SQ_DEPTH);

  typedef enum logic {ARB, HOLD} state_e;

  state_e              state_q;
  logic [NWIDTH-1:0]   hold_g_q;
  logic [NWIDTH-1:0]   rr_ptr_q;
  logic [IDWIDTH-1:0]  id_cnt_q;
  logic [CW-1:0]       cnt_q [NREQ];
  logic [NWIDTH-1:0]   sq_client_q [SQ_DEPTH];
  logic [IDWIDTH-1:0]  sq_id_q [SQ_DEPTH];
  logic [SQ_PTR-1:0]   wr_ptr_q, rd_ptr_q;
  logic [SQ_PTR:0]     sq_cnt_q;
  logic                err_id_q, err_orphan_q;

  logic [NREQ-1:0]     elig, cnt_inc, cnt_dec;
  logic                rr_found;
  logic [NWIDTH-1:0]   rr_g, rr_idx, grant, dst;
  logic [IDWIDTH-1:0]  head_id;
  logic                sq_empty, sq_full;
  logic                req_val, req_fire, rsp_vis, rsp_ready, rsp_fire;

  assign sq_empty = (sq_cnt_q == '0);
  assign sq_full  = (sq_cnt_q == SQ_FULL_CNT);
  assign dst      = sq_client_q[rd_ptr_q];
  assign head_id  = sq_id_q[rd_ptr_q];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.cl_req_val[i] && (cnt_q[i] != CNT_MAX);
    end
  end

  // First eligible client at or after rr_ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_g     = rr_ptr_q;
    rr_idx   = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = NWIDTH'((int'(rr_ptr_q) + k) % NREQ);
      if (!rr_found && elig[rr_idx]) begin
        rr_found = 1'b1;
        rr_g     = rr_idx;
      end
    end
  end

  // A pending request keeps its grant until the ROB takes it.
  assign grant     = (state_q == HOLD) ? hold_g_q : rr_g;
  assign req_val   = !rst && !sq_full && ((state_q == HOLD) || rr_found);
  assign req_fire  = req_val && bus.rob_req_ready;
  assign rsp_vis   = !rst && bus.rob_rsp_val && !sq_empty;
  assign rsp_ready = !rst && !sq_empty && bus.cl_rsp_ready[dst];
  assign rsp_fire  = bus.rob_rsp_val && rsp_ready;

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < NREQ; i++) begin
      cnt_inc[i] = req_fire && (grant == NWIDTH'(i));
      cnt_dec[i] = rsp_fire && (dst == NWIDTH'(i));
    end
  end

  assign bus.rob_req_val   = req_val;
  assign bus.rob_req_addr  = bus.cl_req_addr[grant*AWIDTH +: AWIDTH];
  assign bus.rob_req_param = bus.cl_req_param[grant*PWIDTH +: PWIDTH];
  assign bus.rob_req_ID    = id_cnt_q;
  assign bus.cl_req_ready  = req_fire ? (NREQ'(1) << grant) : '0;
  assign bus.cl_rsp_val    = rsp_vis ? (NREQ'(1) << dst) : '0;
  assign bus.cl_rsp_data   = bus.rob_rsp_data;
  assign bus.cl_rsp_param  = bus.rob_rsp_param;
  assign bus.rob_rsp_ready = rsp_ready;
  assign bus.err_id        = err_id_q;
  assign bus.err_orphan    = err_orphan_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      hold_g_q     <= '0;
      rr_ptr_q     <= '0;
      id_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      sq_cnt_q     <= '0;
      err_id_q     <= 1'b0;
      err_orphan_q <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      if (req_fire) begin
        state_q  <= ARB;
        rr_ptr_q <= NWIDTH'((int'(grant) + 1) % NREQ);
        id_cnt_q <= id_cnt_q + 1'b1;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end else if (req_val) begin
        state_q  <= HOLD;
        hold_g_q <= grant;
      end
      if (rsp_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (head_id != bus.rob_rsp_ID) err_id_q <= 1'b1;
      end
      if (bus.rob_rsp_val && sq_empty) err_orphan_q <= 1'b1;
      case ({req_fire, rsp_fire})
        2'b10:   sq_cnt_q <= sq_cnt_q + 1'b1;
        2'b01:   sq_cnt_q <= sq_cnt_q - 1'b1;
        default: sq_cnt_q <= sq_cnt_q;
      endcase
      for (int i = 0; i < NREQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      sq_client_q[wr_ptr_q] <= grant;
      sq_id_q[wr_ptr_q]     <= id_cnt_q;
    end
  end
endmodule

// File: tb/tb_rob_client_arbiter.sv
// Directed bench for rob_client_arbiter: RR order, credits, HOLD, full FIFO, ID wrap, errors, reset.
module tb_rob_client_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  rob_client_arbiter_if #(.NREQ(4), .AWIDTH(40), .DWIDTH(32), .PWIDTH(32), .IDWIDTH(16)) bus ();

  rob_client_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] nid, rsp_id;
    int outst;
    int iter;

    bus.cl_req_val    = 4'h0;
    bus.cl_rsp_ready  = 4'h0;
    bus.rob_req_ready = 1'b0;
    bus.rob_rsp_val   = 1'b0;
    bus.rob_rsp_data  = '0;
    bus.rob_rsp_ID    = '0;
    bus.rob_rsp_param = '0;
    for (int i = 0; i < 4; i++) begin
      bus.cl_req_addr[i*40 +: 40]  = 40'h1000 + 40'(i);
      bus.cl_req_param[i*32 +: 32] = 32'hA0 + 32'(i);
    end

    // Reset state, with client requests already asserted
    tick();
    tick();
    bus.cl_req_val    = 4'hF;
    bus.rob_req_ready = 1'b1;
    settle();
    chk("rst_req_val", 64'(bus.rob_req_val), 64'd0);
    chk("rst_req_rdy", 64'(bus.cl_req_ready), 64'd0);
    chk("rst_rsp_rdy", 64'(bus.rob_rsp_ready), 64'd0);
    chk("rst_rsp_val", 64'(bus.cl_rsp_val), 64'd0);
    chk("rst_err_id", 64'(bus.err_id), 64'd0);
    chk("rst_err_orphan", 64'(bus.err_orphan), 64'd0);

    // T1: all clients, ROB ready -> grants 0,1,2,3,0,... IDs 0..7
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t1_grant", 64'(bus.cl_req_ready), 64'(4'b0001 << (k % 4)));
      chk("t1_id", 64'(bus.rob_req_ID), 64'(k));
      chk("t1_addr", 64'(bus.rob_req_addr), 64'h1000 + 64'(k % 4));
      chk("t1_param", 64'(bus.rob_req_param), 64'hA0 + 64'(k % 4));
      tick();
    end
    bus.cl_req_val   = 4'h0;
    bus.rob_rsp_val  = 1'b1;
    bus.cl_rsp_ready = 4'hF;
    for (int k = 0; k < 8; k++) begin
      bus.rob_rsp_ID   = 16'(k);
      bus.rob_rsp_data = 32'hD000 + 32'(k);
      settle();
      chk("t1_rsp_route", 64'(bus.cl_rsp_val), 64'(4'b0001 << (k % 4)));
      chk("t1_rsp_data", 64'(bus.cl_rsp_data), 64'hD000 + 64'(k));
      chk("t1_rsp_rdy", 64'(bus.rob_rsp_ready), 64'd1);
      tick();
    end
    bus.rob_rsp_val = 1'b0;

    // T2: client 2 alone, no responses -> exactly MAX_OUT=8 accepts (IDs 8..15)
    bus.cl_req_val = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t2_accept", 64'(bus.cl_req_ready), 64'b0100);
      chk("t2_id", 64'(bus.rob_req_ID), 64'(8 + k));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t2_blocked_rdy", 64'(bus.cl_req_ready), 64'd0);
      chk("t2_blocked_val", 64'(bus.rob_req_val), 64'd0);
      tick();
    end
    bus.rob_rsp_val  = 1'b1;
    bus.rob_rsp_ID   = 16'd8;
    bus.cl_rsp_ready = 4'b0100;
    settle();
    chk("t2_rsp_route", 64'(bus.cl_rsp_val), 64'b0100);
    chk("t2_rdy_same_cycle", 64'(bus.cl_req_ready), 64'd0);
    tick();
    bus.rob_rsp_val = 1'b0;
    settle();
    chk("t2_credit_back", 64'(bus.cl_req_ready), 64'b0100);
    chk("t2_id16", 64'(bus.rob_req_ID), 64'd16);
    tick();
    bus.cl_req_val  = 4'h0;
    bus.rob_rsp_val = 1'b1;
    for (int k = 9; k <= 16; k++) begin
      bus.rob_rsp_ID = 16'(k);
      settle();
      chk("t2_drain", 64'(bus.cl_rsp_val), 64'b0100);
      tick();
    end
    bus.rob_rsp_val = 1'b0;

    // T3: ROB stalls with client 1 granted; client 0 joins but grant holds
    bus.rob_req_ready = 1'b0;
    bus.cl_req_val    = 4'b0010;
    settle();
    chk("t3_val", 64'(bus.rob_req_val), 64'd1);
    chk("t3_addr0", 64'(bus.rob_req_addr), 64'h1001);
    tick();
    bus.cl_req_val = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t3_hold_addr", 64'(bus.rob_req_addr), 64'h1001);
      chk("t3_hold_rdy", 64'(bus.cl_req_ready), 64'd0);
      tick();
    end
    bus.rob_req_ready = 1'b1;
    settle();
    chk("t3_release", 64'(bus.cl_req_ready), 64'b0010);
    chk("t3_id", 64'(bus.rob_req_ID), 64'd17);
    tick();
    settle();
    chk("t3_next", 64'(bus.cl_req_ready), 64'b0001);
    chk("t3_id2", 64'(bus.rob_req_ID), 64'd18);
    tick();
    bus.cl_req_val   = 4'h0;
    bus.rob_rsp_val  = 1'b1;
    bus.cl_rsp_ready = 4'hF;
    bus.rob_rsp_ID   = 16'd17;
    settle();
    chk("t3_rsp1", 64'(bus.cl_rsp_val), 64'b0010);
    tick();
    bus.rob_rsp_ID = 16'd18;
    settle();
    chk("t3_rsp0", 64'(bus.cl_rsp_val), 64'b0001);
    tick();
    bus.rob_rsp_val = 1'b0;

    // T4: stream until id_cnt reaches 0xFFF0 with the FIFO drained
    nid    = 16'd19;
    rsp_id = 16'd19;
    outst  = 0;
    iter   = 0;
    while ((nid != 16'hFFF0 || outst != 0) && iter < 70000) begin
      bus.cl_req_val  = (nid != 16'hFFF0) ? 4'hF : 4'h0;
      bus.rob_rsp_val = (outst != 0);
      bus.rob_rsp_ID  = rsp_id;
      settle();
      if (bus.cl_req_ready != 4'h0) begin
        nid++;
        outst++;
      end
      if (bus.rob_rsp_val && bus.rob_rsp_ready) begin
        rsp_id++;
        outst--;
      end
      tick();
      iter++;
    end
    bus.rob_rsp_val = 1'b0;
    chk("t4_stream_done", 64'(nid == 16'hFFF0 && outst == 0), 64'd1);
    chk("t4_stream_err_id", 64'(bus.err_id), 64'd0);
    // Fill all 16 entries: IDs 0xFFF0..0xFFFF, grants from client 2
    bus.cl_req_val = 4'hF;
    for (int k = 0; k < 16; k++) begin
      settle();
      chk("t4_fill_id", 64'(bus.rob_req_ID), 64'(16'hFFF0 + 16'(k)));
      chk("t4_fill_grant", 64'(bus.cl_req_ready), 64'(4'b0001 << ((2 + k) % 4)));
      tick();
    end
    settle();
    chk("t4_full_val", 64'(bus.rob_req_val), 64'd0);
    chk("t4_wrap_id", 64'(bus.rob_req_ID), 64'd0);
    bus.rob_rsp_val = 1'b1;
    bus.rob_rsp_ID  = 16'hFFF0;
    settle();
    chk("t4_rsp_route", 64'(bus.cl_rsp_val), 64'b0100);
    chk("t4_rsp_rdy", 64'(bus.rob_rsp_ready), 64'd1);
    chk("t4_req_wait", 64'(bus.cl_req_ready), 64'd0);
    tick();
    bus.rob_rsp_val = 1'b0;
    settle();
    chk("t4_req_after", 64'(bus.cl_req_ready), 64'b0100);
    chk("t4_req_id0", 64'(bus.rob_req_ID), 64'd0);
    tick();
    chk("t4_err_orphan", 64'(bus.err_orphan), 64'd0);

    // T6: reset with 16 in flight and traffic active
    bus.rob_rsp_val = 1'b1;
    bus.rob_rsp_ID  = 16'hFFF1;
    settle();
    chk("t6_pre_rsp_rdy", 64'(bus.rob_rsp_ready), 64'd1);
    rst = 1'b1;
    tick();
    settle();
    chk("t6_req_val", 64'(bus.rob_req_val), 64'd0);
    chk("t6_req_rdy", 64'(bus.cl_req_ready), 64'd0);
    chk("t6_rsp_val", 64'(bus.cl_rsp_val), 64'd0);
    chk("t6_rsp_rdy", 64'(bus.rob_rsp_ready), 64'd0);
    chk("t6_err_orphan", 64'(bus.err_orphan), 64'd0);
    rst             = 1'b0;
    bus.rob_rsp_val = 1'b0;
    bus.cl_req_val  = 4'b0001;
    // T5: five requests from client 0 after reset, IDs restart at 0
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t6_t5_accept", 64'(bus.cl_req_ready), 64'b0001);
      chk("t6_t5_id", 64'(bus.rob_req_ID), 64'(k));
      if (k == 0) chk("t6_empty_rdy", 64'(bus.rob_rsp_ready), 64'd0);
      tick();
    end
    bus.cl_req_val  = 4'h0;
    bus.rob_rsp_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.rob_rsp_ID = 16'(k);
      settle();
      chk("t5_rsp", 64'(bus.cl_rsp_val), 64'b0001);
      tick();
    end
    chk("t5_no_err_yet", 64'(bus.err_id), 64'd0);
    bus.rob_rsp_ID = 16'd5;
    settle();
    chk("t5_bad_delivered", 64'(bus.cl_rsp_val), 64'b0001);
    chk("t5_bad_rdy", 64'(bus.rob_rsp_ready), 64'd1);
    tick();
    settle();
    chk("t5_err_id", 64'(bus.err_id), 64'd1);
    chk("t5_orphan_rdy", 64'(bus.rob_rsp_ready), 64'd0);
    chk("t5_orphan_val", 64'(bus.cl_rsp_val), 64'd0);
    chk("t5_orphan_pre", 64'(bus.err_orphan), 64'd0);
    tick();
    bus.rob_rsp_val = 1'b0;
    settle();
    chk("t5_err_orphan", 64'(bus.err_orphan), 64'd1);
    tick();
    tick();
    chk("t5_sticky_id", 64'(bus.err_id), 64'd1);
    chk("t5_sticky_orphan", 64'(bus.err_orphan), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
